seg_display_scanner: RTL and testbench
======================================

// Module: seg_display_scanner
// PURPOSE
//  Time-multiplexes a NUM_DIGITS-digit common-anode 7-segment display onto one shared hex-to-segment decoder.
//  - Sequences digits, presents the active nibble to the decoder and drives per-digit anode enables.
//  - Inserts blanking dead time between digits to prevent ghosting.
//  - Accepts new display values over a valid/ready handshake and commits them atomically at frame boundaries.
//  - Sits between the application counter/datapath and the registered decoder feeding the pads.
// PARAMETERS
//  NUM_DIGITS    4     digits scanned per frame (>=1)
//  DWELL_CYCLES  1000  clk cycles per digit with its anode on (>=1)
//  BLANK_CYCLES  16    clk cycles all anodes off before each digit (>=1); covers decoder's 1-cycle latency
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             asynchronous, active-low reset
//  en           in   1             scan enable; 0 = display dark
//  load_valid   in   1             new value offered
//  load_ready   out  1             pending buffer empty; load accepted when valid&&ready
//  load_value   in   4*NUM_DIGITS  nibble k = digit k (digit 0 = rightmost)
//  digit_data   out  4             nibble to shared decoder (registered)
//  digit_an     out  NUM_DIGITS    one-hot anode enable, active high (registered)
//  frame_done   out  1             1-cycle pulse at end of last digit's dwell
// BEHAVIOUR
//  Reset values: digit_data=0, digit_an=0, frame_done=0, load_ready=1; active and pending registers = 0.
//  FSM states:
//   - IDLE: anodes 0, idx=0, counter=0.
//   - BLANK: anodes 0, digit_data=active[idx], BLANK_CYCLES cycles.
//   - DWELL: digit_an=1<<idx, digit_data held, DWELL_CYCLES cycles.
//  Transitions:
//   - IDLE->BLANK when en=1.
//   - BLANK->DWELL at count BLANK_CYCLES-1.
//   - DWELL->BLANK at count DWELL_CYCLES-1, idx wraps to 0 after NUM_DIGITS-1.
//   - Any state->IDLE the cycle after en=0; digit_an=0 on that edge.
//  Frame length: NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
//  frame_done: asserted the cycle after the last digit's final dwell cycle.
//  Handshake:
//   - valid&&ready captures load_value into pending; load_ready=0 from the next cycle.
//   - Commit pending->active at the last-digit DWELL->BLANK edge, or in the first IDLE cycle with pending set.
//   - load_ready=1 the cycle after commit; active never changes mid-frame.
//   - load_valid high while ready=0 is ignored; the source holds its value.
//  Counter: width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)); reloads to 0 on every state change; never wraps within a state.
//  Reset mid-operation forces all reset values immediately; any pending load is lost.
// CONFIGURATION
//  SEGSCAN_LZB_EN defined: leading-zero blanking.
//   - During DWELL of digit k>0, digit_an stays 0 if active nibbles k..NUM_DIGITS-1 are all zero.
//   - Digit 0 is never blanked; timing and frame_done are unchanged.
//  SEGSCAN_LZB_EN undefined: every digit is lit during its dwell.
// STRUCTURE
//  Package seg_pkg: scan state enum (IDLE/BLANK/DWELL), ANODE_OFF constant, NIBBLE_W=4.
//  Sub-module seg_tick_counter: parameterised dwell/blank counter with clear and terminal-count output.
//  Decoder stays external and shared; this block owns no segment encoding.
// TESTING (NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2)
//  1. rst_n=0 mid-frame with pending load -> all outputs reset values next sample; load_ready=1.
//  2. Load 0x1234 with en=0, then en=1:
//     - 2 dark cycles, then digit_an=0001 and digit_data=4 for 8 cycles, then 0010/3, etc.
//     - frame_done pulses every 40 cycles.
//  3. Load 0xBEEF mid-frame:
//     - load_ready=0 next cycle; 0x1234 shown until frame_done.
//     - Next frame shows F,E,E,B; load_ready=1 the cycle after commit.
//  4. load_valid held with 0x5678 while ready=0 -> not captured until ready=1; exactly one capture.
//  5. en=0 during digit 2 dwell -> digit_an=0 next cycle; en=1 restarts at BLANK, digit 0.
//  6. SEGSCAN_LZB_EN, value 0x0050:
//     - digits 3,2 dark during dwell; digits 1 (5) and 0 (0) lit.
//     - frame_done still every 40 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display scanner.
package seg_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic ANODE_OFF = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } scan_state_e;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seg_tick_counter.sv
// Dwell/blank tick counter: clears on demand, saturates at the terminal value.
module seg_tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Scans NUM_DIGITS hex digits onto one shared external decoder with blanking dead time.
// Define SEGSCAN_LZB_EN to enable leading-zero blanking.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0]   load_value,
    output logic [NIBBLE_W-1:0]              digit_data,
    output logic [NUM_DIGITS-1:0]            digit_an,
    output logic                             frame_done,
    output logic [1:0]                       dbg_state
);

    localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

    scan_state_e      state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [VAL_W-1:0] active;
    logic [VAL_W-1:0] pending;
    logic [VAL_W-1:0] active_next;
    logic             pend_valid;
    logic             last_digit;
    logic             commit;
    logic             digit_lit;
    logic             cnt_clear;
    logic [CNT_W-1:0] cnt_last;
    logic [CNT_W-1:0] cnt;
    logic             tc;

    // Handshake: a load is taken on any edge where load_valid && load_ready; load_ready
    // is simply "pending buffer empty", so a source offering while not ready just holds.
    assign load_ready = !pend_valid;
    assign dbg_state  = state;

    always_comb begin
        cnt_last    = (state == DWELL) ? CNT_W'(DWELL_CYCLES - 1) : CNT_W'(BLANK_CYCLES - 1);
        last_digit  = (idx == IDX_W'(NUM_DIGITS - 1));
        nxt_idx     = last_digit ? '0 : idx + IDX_W'(1);
        commit      = pend_valid && ((state == IDLE) ||
                                     (en && state == DWELL && last_digit && tc));
        active_next = commit ? pending : active;
        cnt_clear   = (state == IDLE) || !en || tc;
    end

    always_comb begin
        digit_lit = 1'b1;
`ifdef SEGSCAN_LZB_EN
        digit_lit = (idx == '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && active[k*NIBBLE_W +: NIBBLE_W] != '0) digit_lit = 1'b1;
        end
`endif
    end

    seg_tick_counter #(.W(CNT_W)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .last  (cnt_last),
        .count (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            digit_data <= '0;
            digit_an   <= {NUM_DIGITS{ANODE_OFF}};
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_valid && !pend_valid) begin
                pending    <= load_value;
                pend_valid <= 1'b1;
            end
            if (commit) begin
                active     <= pending;
                pend_valid <= 1'b0;
            end
            if (!en) begin
                state    <= IDLE;
                idx      <= '0;
                digit_an <= {NUM_DIGITS{ANODE_OFF}};
            end else begin
                case (state)
                    IDLE: begin
                        state      <= BLANK;
                        idx        <= '0;
                        digit_data <= active_next[NIBBLE_W-1:0];
                    end
                    BLANK: begin
                        if (tc) begin
                            state    <= DWELL;
                            digit_an <= digit_lit ? (NUM_DIGITS'(1) << idx)
                                                  : {NUM_DIGITS{ANODE_OFF}};
                        end
                    end
                    DWELL: begin
                        if (tc) begin
                            // New frame data is presented during the blank that follows the commit.
                            state      <= BLANK;
                            digit_an   <= {NUM_DIGITS{ANODE_OFF}};
                            idx        <= nxt_idx;
                            frame_done <= last_digit;
                            digit_data <= active_next[nxt_idx*NIBBLE_W +: NIBBLE_W];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner (4 digits, dwell 8, blank 2); honours SEGSCAN_LZB_EN.
module tb_seg_display_scanner;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic [3:0]  digit_data;
    logic [3:0]  digit_an;
    logic        frame_done;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    logic mon_on = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;
    logic [3:0] prev_an   = 4'b0;
    logic [3:0] hold_data = 4'b0;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] data;
        logic       fd;
    } vec_t;
    vec_t vecs[14];

    seg_display_scanner #(
        .NUM_DIGITS   (4),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .digit_data (digit_data),
        .digit_an   (digit_an),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic step_to(input int t);
        while (k < t) step(1);
    endtask

    // expected lit dwells of one frame, in scan order
    task automatic push_frame(input logic [15:0] v);
        logic lit;
`ifdef SEGSCAN_LZB_EN
        int top;
        top = 0;
        for (int d = 0; d < 4; d++) if (v[d*4 +: 4] != 4'h0) top = d;
`endif
        for (int d = 0; d < 4; d++) begin
            lit = 1'b1;
`ifdef SEGSCAN_LZB_EN
            lit = (d <= top);
`endif
            if (lit) exp_q.push_back({4'(1 << d), v[d*4 +: 4]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},    32'(digit_an),   0);
        check({tag, "_data"},  32'(digit_data), 0);
        check({tag, "_fd"},    32'(frame_done), 0);
        check({tag, "_ready"}, 32'(load_ready), 1);
    endtask

    // scoreboard: each dwell start pops one expected {anode, nibble}
    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (digit_an != 4'b0 && prev_an == 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: actual an=%b data=%h, required no lit dwell", digit_an, digit_data);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_dwell", 32'({digit_an, digit_data}), 32'(sb_exp));
                end
                hold_data = digit_data;
            end else if (digit_an != 4'b0) begin
                check("sb_hold", 32'({digit_an, digit_data}), 32'({prev_an, hold_data}));
            end
        end
        prev_an = digit_an;
    end

    initial begin
        logic lzb;
`ifdef SEGSCAN_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        vecs[0]  = '{1,  4'h0, 4'h4, 1'b0};
        vecs[1]  = '{2,  4'h0, 4'h4, 1'b0};
        vecs[2]  = '{3,  4'h1, 4'h4, 1'b0};
        vecs[3]  = '{10, 4'h1, 4'h4, 1'b0};
        vecs[4]  = '{11, 4'h0, 4'h3, 1'b0};
        vecs[5]  = '{13, 4'h2, 4'h3, 1'b0};
        vecs[6]  = '{20, 4'h2, 4'h3, 1'b0};
        vecs[7]  = '{23, 4'h4, 4'h2, 1'b0};
        vecs[8]  = '{33, 4'h8, 4'h1, 1'b0};
        vecs[9]  = '{40, 4'h8, 4'h1, 1'b0};
        vecs[10] = '{41, 4'h0, 4'h4, 1'b1};
        vecs[11] = '{42, 4'h0, 4'h4, 1'b0};
        vecs[12] = '{43, 4'h1, 4'h4, 1'b0};
        vecs[13] = '{81, 4'h0, 4'h4, 1'b1};

        rst_n      = 1'b0;
        en         = 1'b0;
        load_valid = 1'b0;
        load_value = 16'h0;
        step(2);
        check_reset_outputs("por");
        rst_n = 1'b1;
        step(2);

        // load while dark: commits in IDLE
        load_value = 16'h1234;
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
        check("cap_ready_low", 32'(load_ready), 0);
        step(1);
        check("idle_commit_ready", 32'(load_ready), 1);
        check("idle_dark", 32'(digit_an), 0);

        mon_on = 1'b1;
        repeat (3) push_frame(16'h1234);
        k  = 0;
        en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step_to(vecs[i].cyc);
            check($sformatf("vec%0d_an", i),   32'(digit_an),   32'(vecs[i].an));
            check($sformatf("vec%0d_data", i), 32'(digit_data), 32'(vecs[i].data));
            check($sformatf("vec%0d_fd", i),   32'(frame_done), 32'(vecs[i].fd));
        end

        // mid-frame load held off until the frame boundary
        step_to(95);
        load_value = 16'hBEEF;
        load_valid = 1'b1;
        step(1);
        check("mid_load_ready_low", 32'(load_ready), 0);
        push_frame(16'hBEEF);
        load_value = 16'h5678;
        step_to(120);
        check("busy_ready", 32'(load_ready), 0);
        check("old_value_shown", 32'({digit_an, digit_data}), 32'h81);
        step(1);
        check("commit_fd", 32'(frame_done), 1);
        check("commit_ready", 32'(load_ready), 1);
        check("commit_data", 32'(digit_data), 32'hF);
        step(1);
        check("held_capture", 32'(load_ready), 0);
        load_valid = 1'b0;
        push_frame(16'h5678);
        step_to(161);
        check("fd_period", 32'(frame_done), 1);
        check("new_frame_data", 32'(digit_data), 32'h8);
        step_to(165);
        check("single_capture", 32'(load_ready), 1);

        // scan disable during digit 2, then restart
        step_to(185);
        check("d2_dwell", 32'({digit_an, digit_data}), 32'h46);
        en = 1'b0;
        step(1);
        check("en_off_dark", 32'(digit_an), 0);
        check("sb_left", exp_q.size(), 1);
        exp_q.delete();
        step(3);
        check("idle_an", 32'(digit_an), 0);
        check("idle_fd", 32'(frame_done), 0);
        push_frame(16'h5678);
        k  = 0;
        en = 1'b1;
        step(1);
        check("restart_blank", 32'({digit_an, digit_data}), 32'h08);
        step(2);
        check("restart_d0", 32'({digit_an, digit_data}), 32'h18);

        // value with leading zeros
        load_value = 16'h0050;
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
        repeat (2) push_frame(16'h0050);
        step_to(41);
        check("lz_fd", 32'(frame_done), 1);
        check("lz_d0_data", 32'(digit_data), 0);
        step_to(53);
        check("lz_d1", 32'({digit_an, digit_data}), 32'h25);
        step_to(63);
        check("lz_d2", 32'({digit_an, digit_data}), lzb ? 32'h00 : 32'h40);
        step_to(73);
        check("lz_d3", 32'({digit_an, digit_data}), lzb ? 32'h00 : 32'h80);
        step_to(80);
        check("lz_fd_low", 32'(frame_done), 0);
        step(1);
        check("lz_fd_period", 32'(frame_done), 1);

        // reset mid-frame with a pending load
        step_to(85);
        load_value = 16'h9ABC;
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
        check("pre_rst_pending", 32'(load_ready), 0);
        step_to(95);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        mon_on = 1'b0;
        exp_q.delete();
        step(1);
        rst_n = 1'b1;
        k      = 0;
        mon_on = 1'b1;
        push_frame(16'h0000);
        step_to(3);
        check("post_rst_d0", 32'({digit_an, digit_data}), 32'h10);
        step_to(41);
        check("post_rst_fd", 32'(frame_done), 1);
        check("post_rst_data", 32'(digit_data), 0);
        check("post_rst_ready", 32'(load_ready), 1);
        en = 1'b0;
        step(2);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
